// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC sample buffer: register command codes on
// addr[3:0], the default ID value, the marker returned by a read of an empty
// FIFO, and a helper that packs the STATUS word.
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam logic [3:0] CMD_MASK      = 4'h1;
  localparam logic [3:0] CMD_DECIMATE  = 4'h2;
  localparam logic [3:0] CMD_FIFO_DATA = 4'h3;
  localparam logic [3:0] CMD_COUNT     = 4'h4;
  localparam logic [3:0] CMD_STATUS    = 4'h5;
  localparam logic [3:0] CMD_CLEAR     = 4'h6;
  localparam logic [3:0] CMD_THRESH    = 4'h7;
  localparam logic [3:0] CMD_DROPCNT   = 4'h8;
  localparam logic [3:0] CMD_ID        = 4'h9;

  localparam logic [15:0] DEFAULT_ID = 16'h5B0F;

  // Channel 7 with an all-ones payload is reserved by the ADC, so this value
  // can never be a real sample and safely flags an empty pop.
  localparam logic [15:0] EMPTY_MARK = 16'hFFFF;

  localparam int NUM_CH = 8;

  function automatic logic [15:0] status_word(input logic overflow,
                                              input logic full,
                                              input logic empty);
    return {13'h0, overflow, full, empty};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding DEPTH words. Pointers carry one extra wrap bit so
// full and empty are distinguished without a separate flag. The head word is
// kept in a register that always shows the oldest entry, so a pop can return
// it on the same edge it advances the read pointer.
//
// Ports
//   clk, reset  : clock, synchronous active-high reset
//   push        : write push_data (ignored when full or clearing)
//   push_data   : word to store
//   pop         : discard head (ignored when empty or clearing)
//   clear       : empty the FIFO; wins over push and pop
//   head        : registered oldest word (valid while !empty)
//   count       : number of stored words, 0..DEPTH
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A full FIFO drops the push even if a pop happens in the same cycle.
  assign push_ok = push & ~full & ~clear;
  assign pop_ok  = pop & ~empty & ~clear;
  assign rd_next = rd_ptr[AW-1:0] + AW'(1);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Head register tracks what mem[rd_ptr] will hold after this edge. The
  // only cases where that word is not already in memory are a push into an
  // empty FIFO and a push that coincides with popping the last word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      head <= '0;
    end else if (pop_ok) begin
      if (count == CW'(1)) head <= push_ok ? push_data : '0;
      else                 head <= mem[rd_next];
    end else if (empty && push_ok) begin
      head <= push_data;
    end
  end

endmodule

// File: rtl/adc_sample_buffer.sv
// -----------------------------------------------------------------------------
// adc_sample_buffer
// Receives tagged ADC conversion words, filters them by channel mask and
// per-channel decimation, and queues the survivors in a FIFO that software
// drains over the EBI register bus.
//
// Build option: define ADC_SAMPLE_BUFFER_DROPCNT_EN to add a saturating
// counter of samples dropped on a full FIFO, readable at command 0x8.
// Without it, 0x8 reads 0.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   sample_valid  : one-cycle strobe qualifying sample_data
//   sample_data   : [15:13] channel, [12:0] payload
//   addr          : [15:8] block select, [3:0] command
//   data_in       : bus write data
//   enable        : bus chip enable
//   re, wr        : bus read / write strobes
//   data_out      : registered read data, 0 when not reading
//   fifo_irq      : high while count >= threshold and threshold != 0
// -----------------------------------------------------------------------------
module adc_sample_buffer
  import adc_pkg::*;
#(
  parameter logic [7:0]  POSITION = 8'd1,
  parameter int          DEPTH    = 256,
  parameter logic [15:0] ID_VALUE = DEFAULT_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic [18:0] addr,
  input  logic [15:0] data_in,
  input  logic        enable,
  input  logic        re,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        fifo_irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic        sel;
  logic [3:0]  cmd;
  logic        rd_req;
  logic        wr_req;
  logic        clear;
  logic        dec_wr;

  logic [7:0]  mask;
  logic [15:0] decimate;
  logic [15:0] thresh;
  logic [15:0] dec_cnt [NUM_CH];
  logic        overflow;

  logic [2:0]  ch;
  logic        ch_on;
  logic        keep;

  logic        pop_term;
  logic        pop_term_q;
  logic        pop_edge;

  logic [15:0] head;
  logic [CW-1:0] count;
  logic        full;
  logic        empty;

  logic [15:0] rd_mux;
  logic [15:0] drop_word;
  logic        unused_addr;

  assign unused_addr = ^{addr[18:16], addr[7:4]};

  assign sel    = enable & (addr[15:8] == POSITION);
  assign cmd    = addr[3:0];
  assign rd_req = sel & re;
  assign wr_req = sel & wr;
  assign clear  = wr_req & (cmd == CMD_CLEAR);
  assign dec_wr = wr_req & (cmd == CMD_DECIMATE);

  // Pop only on the first cycle of a FIFO_DATA read so a held re cannot
  // drain more than one word.
  assign pop_term = rd_req & (cmd == CMD_FIFO_DATA);
  assign pop_edge = pop_term & ~pop_term_q;

  assign ch    = sample_data[15:13];
  assign ch_on = sample_valid & mask[ch];
  assign keep  = ch_on & (dec_cnt[ch] == decimate);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (keep),
    .push_data (sample_data),
    .pop       (pop_edge),
    .clear     (clear),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      decimate <= '0;
      thresh   <= '0;
    end else if (wr_req) begin
      case (cmd)
        CMD_MASK:     mask     <= data_in[7:0];
        CMD_DECIMATE: decimate <= data_in;
        CMD_THRESH:   thresh   <= data_in;
        default:      ;
      endcase
    end
  end

  // Masked-off channels leave their counter untouched.
  always_ff @(posedge clk) begin
    if (reset || clear || dec_wr) begin
      for (int i = 0; i < NUM_CH; i++) dec_cnt[i] <= '0;
    end else if (ch_on) begin
      if (keep) dec_cnt[ch] <= '0;
      else      dec_cnt[ch] <= dec_cnt[ch] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear)   overflow <= 1'b0;
    else if (keep && full) overflow <= 1'b1;
  end

`ifdef ADC_SAMPLE_BUFFER_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)
      drop_cnt <= '0;
    else if (keep && full && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end

  assign drop_word = drop_cnt;
`else
  assign drop_word = '0;
`endif

  always_comb begin
    rd_mux = '0;
    case (cmd)
      CMD_COUNT:   rd_mux = 16'(count);
      CMD_STATUS:  rd_mux = status_word(overflow, full, empty);
      CMD_DROPCNT: rd_mux = drop_word;
      CMD_ID:      rd_mux = ID_VALUE;
      default:     rd_mux = '0;
    endcase
  end

  // FIFO_DATA loads data_out only on the popping cycle and then holds it for
  // as long as re stays asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      pop_term_q <= 1'b0;
      fifo_irq   <= 1'b0;
    end else begin
      pop_term_q <= pop_term;
      fifo_irq   <= (thresh != 16'd0) && (16'(count) >= thresh);
      if (!rd_req)
        data_out <= '0;
      else if (cmd == CMD_FIFO_DATA) begin
        if (pop_edge) data_out <= empty ? EMPTY_MARK : head;
      end else
        data_out <= rd_mux;
    end
  end

endmodule

// File: tb/tb_adc_sample_buffer.sv
module tb_adc_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [18:0] addr;
  logic [15:0] data_in;
  logic        enable;
  logic        re;
  logic        wr;
  logic [15:0] data_out;
  logic        fifo_irq;

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] C_MASK     = 4'h1;
  localparam logic [3:0] C_DECIMATE = 4'h2;
  localparam logic [3:0] C_FIFO     = 4'h3;
  localparam logic [3:0] C_COUNT    = 4'h4;
  localparam logic [3:0] C_STATUS   = 4'h5;
  localparam logic [3:0] C_CLEAR    = 4'h6;
  localparam logic [3:0] C_THRESH   = 4'h7;
  localparam logic [3:0] C_DROP     = 4'h8;
  localparam logic [3:0] C_ID       = 4'h9;

`ifdef ADC_SAMPLE_BUFFER_DROPCNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  adc_sample_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .addr         (addr),
    .data_in      (data_in),
    .enable       (enable),
    .re           (re),
    .wr           (wr),
    .data_out     (data_out),
    .fifo_irq     (fifo_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [3:0] cmd);
    addr = {3'b000, 8'h01, 4'h0, cmd};
  endtask

  task automatic bus_write(input logic [3:0] cmd, input logic [15:0] d);
    set_cmd(cmd);
    data_in = d;
    enable  = 1'b1;
    wr      = 1'b1;
    tick();
    enable  = 1'b0;
    wr      = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] cmd, output logic [15:0] v);
    set_cmd(cmd);
    enable = 1'b1;
    re     = 1'b1;
    tick();
    v      = data_out;
    enable = 1'b0;
    re     = 1'b0;
    tick();
  endtask

  task automatic check_reg(input string tag, input logic [3:0] cmd, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(cmd, v);
    check(tag, v, exp);
  endtask

  task automatic push_sample(input logic [15:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    reset = 1'b1; sample_valid = 1'b0; sample_data = '0;
    addr = '0; data_in = '0; enable = 1'b0; re = 1'b0; wr = 1'b0;
    repeat (3) tick();
    check("reset data_out", data_out, 16'h0000);
    check("reset irq", {15'b0, fifo_irq}, 16'h0000);
    reset = 1'b0;
    tick();

    check_reg("reset count", C_COUNT, 16'h0000);
    check_reg("reset status", C_STATUS, 16'h0001);
    check_reg("id", C_ID, 16'h5B0F);
    check_reg("reset dropcnt", C_DROP, 16'h0000);
    check_reg("unlisted 0xA", 4'hA, 16'h0000);
    addr = {3'b000, 8'h02, 4'h0, C_ID}; enable = 1'b1; re = 1'b1;
    tick();
    check("other position", data_out, 16'h0000);
    enable = 1'b0; re = 1'b0;
    tick();

    // Mask is 0 out of reset: nothing captured.
    push_sample(16'h0011);
    check_reg("mask off count", C_COUNT, 16'h0000);

    // Basic capture and in-order readout.
    bus_write(C_MASK, 16'h0001);
    bus_write(C_DECIMATE, 16'h0000);
    push_sample(16'h0011);
    push_sample(16'h0012);
    push_sample(16'h0013);
    check_reg("count 3", C_COUNT, 16'h0003);
    check_reg("pop 1", C_FIFO, 16'h0011);
    check_reg("pop 2", C_FIFO, 16'h0012);
    check_reg("pop 3", C_FIFO, 16'h0013);
    check_reg("pop empty", C_FIFO, 16'hFFFF);
    check_reg("status empty", C_STATUS, 16'h0001);
    check_reg("count after empty pop", C_COUNT, 16'h0000);

    // Decimation by 3 on ch2 with ch1 masked: counter starts at 0 after the
    // DECIMATE write, so the 3rd, 6th and 9th ch2 samples are kept.
    bus_write(C_MASK, 16'h0004);
    bus_write(C_DECIMATE, 16'h0002);
    for (int i = 1; i <= 10; i++) begin
      push_sample(16'h4000 | 16'(i));
      push_sample(16'h2000 | 16'(i));
    end
    check_reg("decim count", C_COUNT, 16'h0003);
    check_reg("decim pop 1", C_FIFO, 16'h4003);
    check_reg("decim pop 2", C_FIFO, 16'h4006);
    check_reg("decim pop 3", C_FIFO, 16'h4009);

    // A masked-off sample must not advance that channel's counter.
    bus_write(C_DECIMATE, 16'h0001);
    push_sample(16'h2001);
    bus_write(C_MASK, 16'h0002);
    push_sample(16'h2002);
    check_reg("masked cnt frozen", C_COUNT, 16'h0000);
    push_sample(16'h2003);
    check_reg("decim1 count", C_COUNT, 16'h0001);
    check_reg("decim1 pop", C_FIFO, 16'h2003);

    // Fill to DEPTH and overflow by two.
    bus_write(C_MASK, 16'h0001);
    bus_write(C_DECIMATE, 16'h0000);
    for (int i = 0; i < 256; i++) push_sample(16'(i));
    push_sample(16'h0777);
    push_sample(16'h0778);
    check_reg("full status", C_STATUS, 16'h0006);
    check_reg("full count", C_COUNT, 16'h0100);
    check_reg("dropcnt 2", C_DROP, DROP_EN ? 16'h0002 : 16'h0000);
    check("irq thresh 0", {15'b0, fifo_irq}, 16'h0000);
    check_reg("full head", C_FIFO, 16'h0000);
    check_reg("ovf sticky", C_STATUS, 16'h0004);
    push_sample(16'h0100);
    // Pop and push on a full FIFO: push still dropped.
    set_cmd(C_FIFO); enable = 1'b1; re = 1'b1;
    sample_valid = 1'b1; sample_data = 16'h0101;
    tick();
    check("pop while full", data_out, 16'h0001);
    enable = 1'b0; re = 1'b0; sample_valid = 1'b0;
    tick();
    check_reg("count 255", C_COUNT, 16'h00FF);
    check_reg("dropcnt 3", C_DROP, DROP_EN ? 16'h0003 : 16'h0000);
    bus_write(C_CLEAR, 16'h0001);
    check_reg("clear status", C_STATUS, 16'h0001);
    check_reg("clear count", C_COUNT, 16'h0000);
    check_reg("clear dropcnt", C_DROP, 16'h0000);

    // CLEAR zeroes decimation counters.
    bus_write(C_DECIMATE, 16'h0001);
    push_sample(16'h0040);
    bus_write(C_CLEAR, 16'h0001);
    push_sample(16'h0041);
    check_reg("clear dec cnt", C_COUNT, 16'h0000);
    push_sample(16'h0042);
    check_reg("clear dec keep", C_FIFO, 16'h0042);

    // Held re pops once and holds data_out.
    bus_write(C_DECIMATE, 16'h0000);
    push_sample(16'h0021);
    push_sample(16'h0022);
    set_cmd(C_FIFO); enable = 1'b1; re = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("held re data", data_out, 16'h0021);
    end
    enable = 1'b0; re = 1'b0;
    tick();
    check("idle data_out", data_out, 16'h0000);
    check_reg("held re count", C_COUNT, 16'h0001);
    check_reg("held re next", C_FIFO, 16'h0022);

    // Same-cycle push and pop at count 1.
    push_sample(16'h0031);
    set_cmd(C_FIFO); enable = 1'b1; re = 1'b1;
    sample_valid = 1'b1; sample_data = 16'h0032;
    tick();
    check("pushpop data", data_out, 16'h0031);
    enable = 1'b0; re = 1'b0; sample_valid = 1'b0;
    tick();
    check_reg("pushpop count", C_COUNT, 16'h0001);
    check_reg("pushpop order", C_FIFO, 16'h0032);

    // Reset mid-read with five words queued.
    bus_write(C_THRESH, 16'h0004);
    for (int i = 0; i < 5; i++) push_sample(16'h0051 + 16'(i));
    tick();
    check("irq before reset", {15'b0, fifo_irq}, 16'h0001);
    set_cmd(C_COUNT); enable = 1'b1; re = 1'b1;
    tick();
    check("count 5", data_out, 16'h0005);
    reset = 1'b1;
    tick();
    check("reset data_out mid", data_out, 16'h0000);
    check("reset irq mid", {15'b0, fifo_irq}, 16'h0000);
    reset = 1'b0; enable = 1'b0; re = 1'b0;
    tick();
    check_reg("reset count mid", C_COUNT, 16'h0000);
    check_reg("reset status mid", C_STATUS, 16'h0001);

    // irq threshold timing.
    bus_write(C_MASK, 16'h0001);
    bus_write(C_THRESH, 16'h0004);
    push_sample(16'h0061);
    push_sample(16'h0062);
    push_sample(16'h0063);
    push_sample(16'h0064);
    check("irq lag", {15'b0, fifo_irq}, 16'h0000);
    tick();
    check("irq rise", {15'b0, fifo_irq}, 16'h0001);
    set_cmd(C_FIFO); enable = 1'b1; re = 1'b1;
    tick();
    check("irq pop data", data_out, 16'h0061);
    check("irq still high", {15'b0, fifo_irq}, 16'h0001);
    enable = 1'b0; re = 1'b0;
    tick();
    check("irq fall", {15'b0, fifo_irq}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
